// File: rtl/hex_scroll_ctrl.sv
// hex_scroll_ctrl: scrolls a six-digit window across a small message of
// 2-bit display codes. Digits feeds the S1/S0 pins of six HEX decoders.
//
// Host interface: Load, Start, Pause and Stop are single-cycle strobes sampled
// on the rising edge of Clk. There is no ready/backpressure; every strobe is
// accepted in the cycle it is seen. Among control strobes Stop beats Pause,
// and Pause beats Start. The exception is IDLE, where Pause has no effect.
module hex_scroll_ctrl #(
  parameter int         MSG_LEN   = 8,
  parameter int         TICK_DIV  = 25000000,
  parameter int         CNT_W     = 25,
  parameter logic [1:0] FILL_CODE = 2'b11
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Load,
  input  logic [3:0]  Wr_addr,
  input  logic [1:0]  Wr_data,
  input  logic        Start,
  input  logic        Pause,
  input  logic        Stop,
  output logic [11:0] Digits,
  output logic [3:0]  Ptr,
  output logic        Busy,
  output logic        Wrap,
  output logic [1:0]  dbg_state
);

  localparam int               AW       = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [3:0]       LAST_IDX = 4'(MSG_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       ptr_n;
  logic             step;
  logic             wr_en;
  logic [1:0]       mem [MSG_LEN];
  logic [11:0]      window;

  assign dbg_state = state;
  assign wr_en     = Load && ({1'b0, Wr_addr} < 5'(MSG_LEN));

  // Message memory: refilled on reset, out-of-range addresses are dropped.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < MSG_LEN; i++) mem[i] <= FILL_CODE;
    end else if (wr_en) begin
      mem[Wr_addr[AW-1:0]] <= Wr_data;
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state plus prescaler/pointer updates; a step is suppressed by Pause.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = Ptr;
    step    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        ptr_n = '0;
        if (Start && !Stop) state_n = RUN;
      end
      RUN: begin
        if (Stop) begin
          state_n = IDLE;
          cnt_n   = '0;
          ptr_n   = '0;
        end else if (Pause) begin
          state_n = HOLD;
        end else if (cnt == CNT_LAST) begin
          cnt_n = '0;
          step  = 1'b1;
          ptr_n = (Ptr == LAST_IDX) ? 4'd0 : Ptr + 4'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (Stop) begin
          state_n = IDLE;
          cnt_n   = '0;
          ptr_n   = '0;
        end else if (!Pause && Start) begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        ptr_n   = '0;
      end
    endcase
  end

  // Window as seen from the current pointer; symbols repeat for short messages.
  always_comb begin
    window = '0;
    for (int j = 0; j < 6; j++) begin
      logic [4:0] idx;
      idx = (5'(Ptr) + 5'(j)) % 5'(MSG_LEN);
      window[(5-j)*2 +: 2] = mem[idx[AW-1:0]];
    end
  end

  // Registered outputs and datapath state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt    <= '0;
      Ptr    <= '0;
      Busy   <= 1'b0;
      Wrap   <= 1'b0;
      Digits <= {6{FILL_CODE}};
    end else begin
      cnt    <= cnt_n;
      Ptr    <= ptr_n;
      Busy   <= (state_n != IDLE);
      Wrap   <= step && (Ptr == LAST_IDX);
      Digits <= window;
    end
  end

endmodule

// File: doc/hex_scroll_ctrl.md
Name: hex_scroll_ctrl

Overview:
- Sequencer for the six HEX digits on the DE1-SoC board.
- Holds a message of 2-bit display codes and scrolls a six-digit window across it at a programmable rate.
- Drives the S1/S0 inputs of six 2-bit HEX decoder instances, one per digit.
- Host logic loads symbols and controls scrolling with single-cycle Start, Pause and Stop strobes.

Parameters:
- MSG_LEN, 8: number of 2-bit symbols in the message. Legal range 1..16.
- TICK_DIV, 25000000: clock cycles per scroll step. Minimum 1.
- CNT_W, 25: prescaler width. Must satisfy 2^CNT_W >= TICK_DIV.
- FILL_CODE, 2'b11: value of every message symbol after reset.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Load  in  1  write strobe for the message memory.
- Wr_addr  in  4  symbol index to write.
- Wr_data  in  2  code to write.
- Start  in  1  begin scrolling (from IDLE) or resume (from HOLD).
- Pause  in  1  freeze scrolling.
- Stop  in  1  abort scrolling and return the window to index 0.
- Digits  out  12  per-digit codes: [11:10] = HEX5 (leftmost) ... [1:0] = HEX0. Bit 1 of each pair goes to S1, bit 0 to S0.
- Ptr  out  4  index of the symbol currently shown on HEX5.
- Busy  out  1  high in RUN or HOLD.
- Wrap  out  1  one-cycle pulse when Ptr wraps to 0.

Behaviour:
- Reset (synchronous, active-high, highest priority, honoured in any state including mid-scroll):
  - all MSG_LEN symbols = FILL_CODE
  - state = IDLE, Ptr = 0, prescaler = 0
  - Busy = 0, Wrap = 0
  - Digits = {6{FILL_CODE}}
- Memory write: Load=1 with Wr_addr < MSG_LEN writes Wr_data at that edge, in any state. Wr_addr >= MSG_LEN is ignored with no side effects.
- Window: HEX(5-j) shows mem[(Ptr + j) mod MSG_LEN] for j = 0..5. If MSG_LEN < 6 the symbols repeat.
- Digits is registered. Its value after edge n+1 is the window computed from Ptr and memory as they stood after edge n, i.e. 1-cycle latency after any Ptr change or memory write.
- State machine (strobe priority Stop > Pause > Start):
  - IDLE: Ptr held at 0, prescaler 0.
    - Start -> RUN, prescaler cleared.
    - Pause is ignored.
  - RUN: prescaler increments each cycle.
    - When prescaler = TICK_DIV-1: prescaler <= 0 and Ptr <= (Ptr+1) mod MSG_LEN.
    - Pause -> HOLD; the step that would occur that cycle is suppressed.
    - Stop -> IDLE.
  - HOLD: prescaler and Ptr frozen.
    - Start -> RUN; counting resumes from the frozen prescaler value.
    - Stop -> IDLE.
  - Stop in any state: Ptr <= 0 and prescaler <= 0 at that edge. No Wrap pulse.
- Simultaneous strobes:
  - Stop and Start together -> Stop wins.
  - Pause and Start in RUN -> HOLD.
  - Pause and Start in HOLD -> stays in HOLD.
- Wrap: registered. Asserts for exactly one cycle, on the same edge a step moves Ptr from MSG_LEN-1 to 0.
- MSG_LEN = 1: every step produces a Wrap pulse; Ptr stays 0.
- TICK_DIV = 1: one step every RUN cycle.
- Busy is registered and equals (state != IDLE).
- A Load during RUN is shown one cycle after the write, without disturbing the scroll timing.

Test Plan:
All scenarios use TICK_DIV=4, MSG_LEN=8 unless noted.
1. Reset then idle -> Digits=12'hFFF, Ptr=0, Busy=0, Wrap=0. Start/Pause absent: no change over 20 cycles.
2. Load mem[0..7] = 0,1,2,3,0,1,2,3, then Start:
   - Busy rises 1 cycle after Start.
   - Ptr steps every 4 cycles: 1, 2, ..., 7, 0.
   - Digits one cycle after Ptr=1 = codes 1,2,3,0,1,2 (12'h6C6).
   - Wrap pulses once, on the step 7 -> 0.
3. RUN, Pause asserted 2 cycles after a step -> Ptr frozen for 10 cycles, Busy=1. Start -> next step occurs 2 cycles later, because the prescaler resumes from its frozen value.
4. RUN at Ptr=5, Stop together with Start -> IDLE next edge, Ptr=0, Busy=0, no Wrap. Digits shows the index-0 window one cycle later.
5. RUN, Load Wr_addr=9 (out of range) -> memory and timing unchanged. Load Wr_addr=Ptr, Wr_data=2'b10 -> Digits[11:10]=2'b10 one cycle later; step cadence unchanged.
6. MSG_LEN=1, TICK_DIV=1, Start -> Wrap high every cycle while in RUN, Ptr stays 0. Reset asserted mid-run -> all outputs at reset values at the next edge.
